// File: rtl/disp_digit_loader_pkg.sv
// Shared encodings for the display digit loader: command codes, FSM states
// and buffer geometry.
package disp_digit_loader_pkg;

    localparam int DIGITS = 16;
    localparam int SIG_W  = 4 * DIGITS;
    localparam int CNT_W  = 5;
    localparam int N_W    = 3;

    typedef enum logic [1:0] {
        CMD_PUSH      = 2'b00,
        CMD_BACKSPACE = 2'b01,
        CMD_CLEAR     = 2'b10,
        CMD_COMMIT    = 2'b11
    } cmd_e;

    typedef enum logic {
        ST_EDIT   = 1'b0,
        ST_SCROLL = 1'b1
    } state_e;

endpackage

// File: rtl/disp_prescaler.sv
// Free-running divider: counts 0..DIV-1 while enabled and emits a one-cycle
// tick on the wrap edge. Synchronous clear forces the count back to zero.
module disp_prescaler #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Tick is combinational so the consumer updates on the same edge the count wraps.
    assign tick = en && !clr && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/disp_digit_loader.sv
// Collects hex digits into a 16-digit shift buffer for the seven-segment
// scanner, then scrolls the view offset once the entry is committed.
module disp_digit_loader
    import disp_digit_loader_pkg::*;
#(
    parameter int unsigned SCROLL_DIV = 50000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_cmd,
    input  logic [3:0]       in_digit,
    input  logic             scroll_en,
    output logic [SIG_W-1:0] signal,
    output logic [N_W-1:0]   n,
    output logic [CNT_W-1:0] count,
    output logic             scrolling
);

    state_e             state_q, state_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_W-1:0]     n_q, n_d;
    logic               ready_q;
    logic               accept;
    logic               presc_clr;
    logic               tick;
    cmd_e               cmd;

    assign cmd    = cmd_e'(in_cmd);
    assign accept = in_valid && ready_q;

    disp_prescaler #(
        .DIV (SCROLL_DIV)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .clr  (presc_clr),
        .en   (scroll_en),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        sig_d     = sig_q;
        cnt_d     = cnt_q;
        n_d       = n_q;
        presc_clr = 1'b0;
        unique case (state_q)
            ST_EDIT: begin
                n_d       = '0;
                presc_clr = 1'b1;
                if (accept) begin
                    unique case (cmd)
                        CMD_PUSH: begin
                            // Full buffer still shifts; the oldest digit falls off the top.
                            sig_d = {sig_q[SIG_W-5:0], in_digit};
                            if (cnt_q != CNT_W'(DIGITS)) cnt_d = cnt_q + 1'b1;
                        end
                        CMD_BACKSPACE: begin
                            if (cnt_q != '0) begin
                                sig_d = {4'h0, sig_q[SIG_W-1:4]};
                                cnt_d = cnt_q - 1'b1;
                            end
                        end
                        CMD_CLEAR: begin
                            sig_d = '0;
                            cnt_d = '0;
                        end
                        CMD_COMMIT: begin
                            if (cnt_q != '0) state_d = ST_SCROLL;
                        end
                        default: ;
                    endcase
                end
            end
            ST_SCROLL: begin
                if (tick) n_d = n_q + 1'b1;
                // Only CLEAR is honoured while scrolling, and it overrides a coincident step.
                if (accept && cmd == CMD_CLEAR) begin
                    sig_d     = '0;
                    cnt_d     = '0;
                    n_d       = '0;
                    presc_clr = 1'b1;
                    state_d   = ST_EDIT;
                end
            end
            default: state_d = ST_EDIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EDIT;
            sig_q   <= '0;
            cnt_q   <= '0;
            n_q     <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            ready_q <= 1'b1;
        end
    end

    assign in_ready  = ready_q;
    assign signal    = sig_q;
    assign n         = n_q;
    assign count     = cnt_q;
    assign scrolling = (state_q == ST_SCROLL);

endmodule

// File: tb/tb_disp_digit_loader.sv
// Directed bench for disp_digit_loader with SCROLL_DIV=4: a vector table for
// edit-mode commands, plus hand-written scroll, clear and reset sequences.
module tb_disp_digit_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_cmd;
    logic [3:0]  in_digit;
    logic        scroll_en;
    logic [63:0] signal;
    logic [2:0]  n;
    logic [4:0]  count;
    logic        scrolling;

    int n_pass = 0;
    int n_total = 0;

    localparam logic [1:0] PUSH = 2'b00, BKSP = 2'b01, CLR = 2'b10, CMT = 2'b11;

    typedef struct {
        logic [1:0]  cmd;
        logic [3:0]  digit;
        logic [63:0] exp_sig;
        logic [4:0]  exp_cnt;
        logic        exp_scr;
    } vec_t;

    vec_t vecs[$];

    disp_digit_loader #(.SCROLL_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cmd    (in_cmd),
        .in_digit  (in_digit),
        .scroll_en (scroll_en),
        .signal    (signal),
        .n         (n),
        .count     (count),
        .scrolling (scrolling)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic tick_n(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [1:0] c, input logic [3:0] d);
        in_valid = 1'b1;
        in_cmd   = c;
        in_digit = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic vec_t mk(input logic [1:0] c, input logic [3:0] d,
                                input logic [63:0] s, input logic [4:0] k, input logic scr);
        vec_t v;
        v.cmd = c; v.digit = d; v.exp_sig = s; v.exp_cnt = k; v.exp_scr = scr;
        return v;
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_cmd = PUSH; in_digit = 4'h0; scroll_en = 1'b0;

        vecs.push_back(mk(PUSH, 4'h4, 64'h4,    5'd1, 1'b0));
        vecs.push_back(mk(PUSH, 4'h3, 64'h43,   5'd2, 1'b0));
        vecs.push_back(mk(PUSH, 4'h2, 64'h432,  5'd3, 1'b0));
        vecs.push_back(mk(PUSH, 4'h6, 64'h4326, 5'd4, 1'b0));
        vecs.push_back(mk(BKSP, 4'h0, 64'h432,  5'd3, 1'b0));
        vecs.push_back(mk(BKSP, 4'h0, 64'h43,   5'd2, 1'b0));
        vecs.push_back(mk(BKSP, 4'h0, 64'h4,    5'd1, 1'b0));
        vecs.push_back(mk(BKSP, 4'h0, 64'h0,    5'd0, 1'b0));
        vecs.push_back(mk(BKSP, 4'h0, 64'h0,    5'd0, 1'b0));
        vecs.push_back(mk(CMT,  4'h0, 64'h0,    5'd0, 1'b0));
        vecs.push_back(mk(PUSH, 4'h0, 64'h0,                5'd1,  1'b0));
        vecs.push_back(mk(PUSH, 4'h1, 64'h01,               5'd2,  1'b0));
        vecs.push_back(mk(PUSH, 4'h2, 64'h012,              5'd3,  1'b0));
        vecs.push_back(mk(PUSH, 4'h3, 64'h0123,             5'd4,  1'b0));
        vecs.push_back(mk(PUSH, 4'h4, 64'h01234,            5'd5,  1'b0));
        vecs.push_back(mk(PUSH, 4'h5, 64'h012345,           5'd6,  1'b0));
        vecs.push_back(mk(PUSH, 4'h6, 64'h0123456,          5'd7,  1'b0));
        vecs.push_back(mk(PUSH, 4'h7, 64'h01234567,         5'd8,  1'b0));
        vecs.push_back(mk(PUSH, 4'h8, 64'h012345678,        5'd9,  1'b0));
        vecs.push_back(mk(PUSH, 4'h9, 64'h0123456789,       5'd10, 1'b0));
        vecs.push_back(mk(PUSH, 4'hA, 64'h0123456789A,      5'd11, 1'b0));
        vecs.push_back(mk(PUSH, 4'hB, 64'h0123456789AB,     5'd12, 1'b0));
        vecs.push_back(mk(PUSH, 4'hC, 64'h0123456789ABC,    5'd13, 1'b0));
        vecs.push_back(mk(PUSH, 4'hD, 64'h0123456789ABCD,   5'd14, 1'b0));
        vecs.push_back(mk(PUSH, 4'hE, 64'h0123456789ABCDE,  5'd15, 1'b0));
        vecs.push_back(mk(PUSH, 4'hF, 64'h0123456789ABCDEF, 5'd16, 1'b0));
        vecs.push_back(mk(PUSH, 4'h1, 64'h123456789ABCDEF1, 5'd16, 1'b0));
        vecs.push_back(mk(PUSH, 4'h2, 64'h23456789ABCDEF12, 5'd16, 1'b0));
        vecs.push_back(mk(BKSP, 4'h0, 64'h023456789ABCDEF1, 5'd15, 1'b0));
        vecs.push_back(mk(CLR,  4'h0, 64'h0,                5'd0,  1'b0));

        // Reset state
        tick_n(2);
        chk("rst_signal", signal, 64'h0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_n", 64'(n), 64'd0);
        chk("rst_scrolling", 64'(scrolling), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        tick_n(1);
        chk("ready_after_rst", 64'(in_ready), 64'd1);

        foreach (vecs[i]) begin
            send(vecs[i].cmd, vecs[i].digit);
            chk($sformatf("vec%0d_signal", i), signal, vecs[i].exp_sig);
            chk($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_scrolling", i), 64'(scrolling), 64'(vecs[i].exp_scr));
            chk($sformatf("vec%0d_n", i), 64'(n), 64'd0);
        end

        // Commit and scroll: n steps every 4 edges, wraps after 32
        send(PUSH, 4'h4); send(PUSH, 4'h3); send(PUSH, 4'h2); send(PUSH, 4'h6);
        scroll_en = 1'b1;
        send(CMT, 4'h0);
        chk("commit_scrolling", 64'(scrolling), 64'd1);
        chk("commit_n", 64'(n), 64'd0);
        for (int e = 1; e <= 32; e++) begin
            tick_n(1);
            chk($sformatf("scroll_e%0d_n", e), 64'(n), 64'((e / 4) % 8));
        end
        tick_n(9);
        chk("scroll_pre_freeze_n", 64'(n), 64'd2);
        scroll_en = 1'b0;
        tick_n(10);
        chk("freeze_n", 64'(n), 64'd2);
        scroll_en = 1'b1;
        tick_n(2);
        chk("resume_hold_n", 64'(n), 64'd2);
        tick_n(1);
        chk("resume_step_n", 64'(n), 64'd3);
        scroll_en = 1'b0;

        // Non-CLEAR commands are dropped while scrolling
        send(PUSH, 4'h9);
        send(BKSP, 4'h0);
        send(CMT, 4'h0);
        chk("scroll_drop_signal", signal, 64'h4326);
        chk("scroll_drop_count", 64'(count), 64'd4);
        chk("scroll_drop_scrolling", 64'(scrolling), 64'd1);
        chk("scroll_drop_n", 64'(n), 64'd3);
        send(CLR, 4'h0);
        chk("scroll_clr_signal", signal, 64'h0);
        chk("scroll_clr_count", 64'(count), 64'd0);
        chk("scroll_clr_n", 64'(n), 64'd0);
        chk("scroll_clr_scrolling", 64'(scrolling), 64'd0);

        // CLEAR coinciding with a scroll step: CLEAR wins
        send(PUSH, 4'h5);
        scroll_en = 1'b1;
        send(CMT, 4'h0);
        tick_n(3);
        chk("race_pre_n", 64'(n), 64'd0);
        send(CLR, 4'h0);
        chk("race_n", 64'(n), 64'd0);
        chk("race_scrolling", 64'(scrolling), 64'd0);
        tick_n(4);
        chk("race_edit_n_held", 64'(n), 64'd0);

        // Reset during SCROLL with n=5, transfer presented that cycle is lost
        send(PUSH, 4'h7);
        send(CMT, 4'h0);
        tick_n(20);
        chk("pre_rst_n", 64'(n), 64'd5);
        rst = 1'b1; in_valid = 1'b1; in_cmd = PUSH; in_digit = 4'hA;
        tick_n(1);
        chk("midrst_signal", signal, 64'h0);
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_n", 64'(n), 64'd0);
        chk("midrst_scrolling", 64'(scrolling), 64'd0);
        chk("midrst_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        tick_n(1);
        chk("post_rst_ready", 64'(in_ready), 64'd1);
        chk("post_rst_no_xfer", signal, 64'h0);
        tick_n(1);
        in_valid = 1'b0;
        chk("post_rst_xfer_signal", signal, 64'hA);
        chk("post_rst_xfer_count", 64'(count), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
